// File: rtl/instr_fetch_decode_if.sv
// PDP-8 fetch/decode stage: decoded-instruction payload types and the
// memory / execute-facing bus interface.

package instr_fetch_decode_pkg;

  localparam int unsigned PDP_ADDR_W = 12;

  // Memory-reference instruction flags plus the resolved operand address
  typedef struct packed {
    logic                  AND;
    logic                  TAD;
    logic                  ISZ;
    logic                  DCA;
    logic                  JMS;
    logic                  JMP;
    logic [PDP_ADDR_W-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  // Operate-group (opcode 7) flags, one per recognised microcoded word
  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;

endpackage

interface instr_fetch_decode_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12
);

  logic                                    ifd_mem_rd_req;
  logic [ADDR_WIDTH-1:0]                   ifd_mem_addr;
  logic                                    ifd_mem_rd_vld;
  logic [DATA_WIDTH-1:0]                   ifd_mem_rd_data;
  logic                                    stall;
  logic [ADDR_WIDTH-1:0]                   PC_value;
  logic [ADDR_WIDTH-1:0]                   base_addr;
  instr_fetch_decode_pkg::pdp_mem_opcode_s pdp_mem_opcode;
  instr_fetch_decode_pkg::pdp_op7_opcode_s pdp_op7_opcode;

  // Fetch/decode side
  modport master (
    output ifd_mem_rd_req, ifd_mem_addr, base_addr, pdp_mem_opcode, pdp_op7_opcode,
    input  ifd_mem_rd_vld, ifd_mem_rd_data, stall, PC_value
  );

  // Memory and execute side
  modport slave (
    input  ifd_mem_rd_req, ifd_mem_addr, base_addr, pdp_mem_opcode, pdp_op7_opcode,
    output ifd_mem_rd_vld, ifd_mem_rd_data, stall, PC_value
  );

endinterface

// File: rtl/instr_fetch_decode.sv
// PDP-8 instruction fetch/decode stage: fetches one word at PC, decodes it
// into one-hot flags, holds them through the execute stall, then takes the
// next PC from execute. Returning base_addr as the next PC halts the stage.

module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200
) (
  input logic                  clk,
  input logic                  reset_n,
  instr_fetch_decode_if.master bus
);

  localparam int unsigned PAGE_LSB = 7;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    WAIT_MEM = 3'd1,
    DECODE   = 3'd2,
    PRESENT  = 3'd3,
    STALLED  = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  rd_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  pdp_mem_opcode_s       mem_op_q;
  pdp_op7_opcode_s       op7_q;

  pdp_mem_opcode_s       mem_dec_c;
  pdp_op7_opcode_s       op7_dec_c;
  logic                  mem_hit_c;
  logic                  legal_c;

  // Decode the latched word; indirect bit (word[8]) is left to execute
  always_comb begin
    mem_dec_c = '0;
    op7_dec_c = '0;
    mem_hit_c = (word_q[11:9] < 3'o6);
    case (word_q[11:9])
      3'o0: mem_dec_c.AND = 1'b1;
      3'o1: mem_dec_c.TAD = 1'b1;
      3'o2: mem_dec_c.ISZ = 1'b1;
      3'o3: mem_dec_c.DCA = 1'b1;
      3'o4: mem_dec_c.JMS = 1'b1;
      3'o5: mem_dec_c.JMP = 1'b1;
      3'o7: begin
        case (word_q)
          12'o7000: op7_dec_c.NOP     = 1'b1;
          12'o7001: op7_dec_c.IAC     = 1'b1;
          12'o7004: op7_dec_c.RAL     = 1'b1;
          12'o7006: op7_dec_c.RTL     = 1'b1;
          12'o7010: op7_dec_c.RAR     = 1'b1;
          12'o7012: op7_dec_c.RTR     = 1'b1;
          12'o7020: op7_dec_c.CML     = 1'b1;
          12'o7040: op7_dec_c.CMA     = 1'b1;
          12'o7041: op7_dec_c.CIA     = 1'b1;
          12'o7100: op7_dec_c.CLL     = 1'b1;
          12'o7200: op7_dec_c.CLA1    = 1'b1;
          12'o7300: op7_dec_c.CLA_CLL = 1'b1;
          12'o7402: op7_dec_c.HLT     = 1'b1;
          12'o7404: op7_dec_c.OSR     = 1'b1;
          12'o7410: op7_dec_c.SKP     = 1'b1;
          12'o7420: op7_dec_c.SNL     = 1'b1;
          12'o7430: op7_dec_c.SZL     = 1'b1;
          12'o7440: op7_dec_c.SZA     = 1'b1;
          12'o7450: op7_dec_c.SNA     = 1'b1;
          12'o7500: op7_dec_c.SMA     = 1'b1;
          12'o7510: op7_dec_c.SPA     = 1'b1;
          12'o7600: op7_dec_c.CLA2    = 1'b1;
          default:  op7_dec_c         = '0;
        endcase
      end
      default: mem_dec_c = '0;
    endcase
    if (mem_hit_c) begin
      // Current-page vs page-zero operand address
      mem_dec_c.mem_inst_addr = word_q[PAGE_LSB] ?
        {pc_q[ADDR_WIDTH-1:PAGE_LSB], word_q[PAGE_LSB-1:0]} :
        {(ADDR_WIDTH-PAGE_LSB)'(0), word_q[PAGE_LSB-1:0]};
    end
    legal_c = mem_hit_c | (|op7_dec_c);
  end

  // Fetch/decode sequencer with registered bus outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      pc_q       <= START_ADDR;
      word_q     <= '0;
      rd_req_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_op_q   <= '0;
      op7_q      <= '0;
    end else begin
      rd_req_q <= 1'b0;
      case (state_q)
        FETCH: begin
          rd_req_q   <= 1'b1;
          mem_addr_q <= pc_q;
          state_q    <= WAIT_MEM;
        end
        WAIT_MEM: begin
          if (bus.ifd_mem_rd_vld) begin
            word_q  <= bus.ifd_mem_rd_data;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          mem_op_q <= mem_dec_c;
          op7_q    <= op7_dec_c;
          if (legal_c) begin
            state_q <= PRESENT;
          end else begin
            // Undecodable words are skipped without an execute handshake
            pc_q    <= pc_q + ADDR_WIDTH'(1);
            state_q <= FETCH;
          end
        end
        PRESENT: begin
          if (bus.stall) state_q <= STALLED;
        end
        STALLED: begin
          if (!bus.stall) begin
            mem_op_q <= '0;
            op7_q    <= '0;
            if (bus.PC_value != START_ADDR) begin
              pc_q    <= bus.PC_value;
              state_q <= FETCH;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.ifd_mem_rd_req = rd_req_q;
  assign bus.ifd_mem_addr   = mem_addr_q;
  assign bus.base_addr      = START_ADDR;
  assign bus.pdp_mem_opcode = mem_op_q;
  assign bus.pdp_op7_opcode = op7_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed scenarios followed by
// randomized instruction streams scored against a table-driven decode model.

module tb_instr_fetch_decode;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  logic [11:0] pc_m;

  instr_fetch_decode_if bus ();

  instr_fetch_decode dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] op7_tab [22] = '{
    12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012,
    12'o7020, 12'o7040, 12'o7041, 12'o7100, 12'o7200, 12'o7300,
    12'o7402, 12'o7404, 12'o7410, 12'o7420, 12'o7430, 12'o7440,
    12'o7450, 12'o7500, 12'o7510, 12'o7600
  };

  // Expected flag vectors: mem flags in [17:12] (AND first), address in [11:0];
  // operate flags indexed by table position (NOP is the top bit)
  function automatic void model(input logic [11:0] w, input logic [11:0] pc,
                                output logic [17:0] em, output logic [21:0] e7);
    int op;
    em = '0;
    e7 = '0;
    op = int'(w[11:9]);
    if (op <= 5) begin
      em[17 - op] = 1'b1;
      em[11:0] = w[7] ? ((pc & 12'o7600) | (w & 12'o0177)) : (w & 12'o0177);
    end else if (op == 7) begin
      for (int i = 0; i < 22; i++) if (op7_tab[i] == w) e7[21 - i] = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: request, memory reply, flag check, stall handshake
  task automatic run_instr(input logic [11:0] word, input int lat, input int pre,
                           input int stall_n, input logic [11:0] next_pc, input string tag);
    logic [17:0] em;
    logic [21:0] e7;
    logic [17:0] am;
    logic [21:0] a7;
    int n;
    n = 0;
    while (bus.ifd_mem_rd_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (bus.ifd_mem_rd_req !== 1'b1) begin
      bad++;
      $display("FAIL %s req_timeout: rd_req=%b required 1", tag, bus.ifd_mem_rd_req);
      return;
    end
    total++;
    if (bus.ifd_mem_addr !== pc_m) begin
      bad++;
      $display("FAIL %s fetch_addr: got %o required %o", tag, bus.ifd_mem_addr, pc_m);
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) begin
        total++;
        if (bus.ifd_mem_rd_req !== 1'b0) begin
          bad++;
          $display("FAIL %s req_pulse: rd_req=%b required 0", tag, bus.ifd_mem_rd_req);
        end
      end
    end
    bus.ifd_mem_rd_vld  = 1'b1;
    bus.ifd_mem_rd_data = word;
    tick();
    bus.ifd_mem_rd_vld  = 1'b0;
    bus.ifd_mem_rd_data = $urandom();
    tick();
    model(word, pc_m, em, e7);
    am = bus.pdp_mem_opcode;
    a7 = bus.pdp_op7_opcode;
    total++;
    if (am !== em || a7 !== e7) begin
      bad++;
      $display("FAIL %s decode %o: mem=%o op7=%h required mem=%o op7=%h",
               tag, word, am, a7, em, e7);
    end
    if (em == '0 && e7 == '0) begin
      pc_m = pc_m + 12'd1;
      return;
    end
    for (int i = 0; i < pre; i++) tick();
    bus.stall = 1'b1;
    for (int i = 0; i < stall_n; i++) begin
      tick();
      am = bus.pdp_mem_opcode;
      a7 = bus.pdp_op7_opcode;
      total++;
      if (am !== em || a7 !== e7) begin
        bad++;
        $display("FAIL %s hold: mem=%o op7=%h required mem=%o op7=%h", tag, am, a7, em, e7);
      end
    end
    bus.stall    = 1'b0;
    bus.PC_value = next_pc;
    tick();
    bus.PC_value = 12'($urandom());
    am = bus.pdp_mem_opcode;
    a7 = bus.pdp_op7_opcode;
    total++;
    if (am !== '0 || a7 !== '0) begin
      bad++;
      $display("FAIL %s clear: mem=%o op7=%h required 0", tag, am, a7);
    end
    if (next_pc != 12'o0200) pc_m = next_pc;
  endtask

  task automatic test_reset();
    logic [17:0] am;
    logic [21:0] a7;
    reset_n = 1'b0;
    repeat (3) tick();
    am = bus.pdp_mem_opcode;
    a7 = bus.pdp_op7_opcode;
    total++;
    if (bus.ifd_mem_rd_req !== 1'b0 || bus.ifd_mem_addr !== 12'o0) begin
      bad++;
      $display("FAIL reset_bus: req=%b addr=%o required 0/0000", bus.ifd_mem_rd_req, bus.ifd_mem_addr);
    end
    total++;
    if (am !== '0 || a7 !== '0) begin
      bad++;
      $display("FAIL reset_flags: mem=%o op7=%h required 0", am, a7);
    end
    total++;
    if (bus.base_addr !== 12'o0200) begin
      bad++;
      $display("FAIL reset_base: got %o required 0200", bus.base_addr);
    end
    reset_n = 1'b1;
    pc_m = 12'o0200;
  endtask

  task automatic test_tad();
    run_instr(12'o1205, 1, 0, 1, 12'o0400, "tad");
  endtask

  task automatic test_cia_stall();
    run_instr(12'o7041, 2, 1, 5, 12'o0345, "cia");
    run_instr(12'o7000, 1, 0, 2, 12'o7777, "nop");
  endtask

  task automatic test_iot_wrap();
    run_instr(12'o6031, 1, 0, 1, 12'o0001, "iot");
    total++;
    if (pc_m !== 12'o0000) begin
      bad++;
      $display("FAIL iot_pc_model: got %o required 0000", pc_m);
    end
  endtask

  task automatic test_jmp_done();
    run_instr(12'o5377, 3, 0, 1, 12'o0200, "jmp");
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if (bus.ifd_mem_rd_req !== 1'b0 || bus.pdp_mem_opcode !== '0 || bus.pdp_op7_opcode !== '0) begin
        bad++;
        $display("FAIL done_idle cyc %0d: req=%b mem=%o required 0", i, bus.ifd_mem_rd_req,
                 bus.pdp_mem_opcode);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    pc_m = 12'o0200;
    n = 0;
    while (bus.ifd_mem_rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    reset_n = 1'b0;
    bus.ifd_mem_rd_vld  = 1'b1;
    bus.ifd_mem_rd_data = 12'o1205;
    tick();
    tick();
    total++;
    if (bus.pdp_mem_opcode !== '0 || bus.pdp_op7_opcode !== '0 || bus.ifd_mem_rd_req !== 1'b0) begin
      bad++;
      $display("FAIL midreset_flags: mem=%o req=%b required 0", bus.pdp_mem_opcode, bus.ifd_mem_rd_req);
    end
    reset_n = 1'b1;
    tick();
    bus.ifd_mem_rd_vld = 1'b0;
    total++;
    if (bus.pdp_mem_opcode !== '0 || bus.pdp_op7_opcode !== '0) begin
      bad++;
      $display("FAIL midreset_stray: mem=%o required 0", bus.pdp_mem_opcode);
    end
    run_instr(12'o7402, 2, 0, 3, 12'o1000, "post_reset");
  endtask

  task automatic test_random();
    logic [11:0] w;
    logic [11:0] nxt;
    int kind;
    for (int k = 0; k < 3000; k++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0) w = {3'($urandom_range(0, 5)), 9'($urandom())};
      else if (kind == 1) w = op7_tab[$urandom_range(0, 21)];
      else w = {2'b11, 10'($urandom())};
      do nxt = 12'($urandom()); while (nxt == 12'o0200);
      run_instr(w, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                int'($urandom_range(1, 20)), nxt, "rand");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pc_m  = 12'o0200;
    reset_n             = 1'b0;
    bus.ifd_mem_rd_vld  = 1'b0;
    bus.ifd_mem_rd_data = '0;
    bus.stall           = 1'b0;
    bus.PC_value        = '0;
    test_reset();
    test_tad();
    test_cia_stall();
    test_iot_wrap();
    test_jmp_done();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
